// File: rtl/hc_sr04_ranger.sv
// hc_sr04_ranger: HC-SR04 trigger/echo ranging controller.
// Echo width is turned into centimetres by a per-cm prescaler.
module hc_sr04_ranger #(
    parameter int TRIG_CYCLES    = 250,
    parameter int CLKS_PER_CM    = 1450,
    parameter int MAX_CM         = 400,
    parameter int WAIT_TIMEOUT   = 750000,
    parameter int HOLDOFF_CYCLES = 1500000,
    parameter int DIST_W         = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cont,
    input  logic              start,
    input  logic              echo,
    output logic              trigger,
    output logic [DIST_W-1:0] distance_cm,
    output logic              valid,
    output logic              timeout,
    output logic              busy
);
    localparam int TM0 = (WAIT_TIMEOUT > HOLDOFF_CYCLES) ? WAIT_TIMEOUT : HOLDOFF_CYCLES;
    localparam int TMX = (TM0 > TRIG_CYCLES) ? TM0 : TRIG_CYCLES;
    localparam int TW  = $clog2(TMX + 1);
    localparam int CW  = $clog2(MAX_CM + 1);
    localparam int SW  = $clog2(CLKS_PER_CM + 1);

    localparam logic [TW-1:0] TRIG_LAST = TW'(TRIG_CYCLES - 1);
    localparam logic [TW-1:0] WAIT_LAST = TW'(WAIT_TIMEOUT - 1);
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLDOFF_CYCLES - 1);
    localparam logic [SW-1:0] SUB_LAST  = SW'(CLKS_PER_CM - 1);
    localparam logic [CW-1:0] CM_MAX    = CW'(MAX_CM);

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        DONE_TO,
        HOLDOFF
    } state_t;

    state_t            state, state_n;
    logic [TW-1:0]     timer, timer_n;
    logic [CW-1:0]     cm_cnt, cm_n;
    logic [SW-1:0]     sub_cnt, sub_n;
    logic              echo_m, echo_s, echo_d;
    logic              trig_n, valid_n, to_n;
    logic [DIST_W-1:0] dist_n;
    logic              rise, fall;

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;
    assign busy = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            timer       <= '0;
            cm_cnt      <= '0;
            sub_cnt     <= '0;
            echo_m      <= 1'b0;
            echo_s      <= 1'b0;
            echo_d      <= 1'b0;
            trigger     <= 1'b0;
            distance_cm <= '0;
            valid       <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            state       <= state_n;
            timer       <= timer_n;
            cm_cnt      <= cm_n;
            sub_cnt     <= sub_n;
            echo_m      <= echo;
            echo_s      <= echo_m;
            echo_d      <= echo_s;
            trigger     <= trig_n;
            distance_cm <= dist_n;
            valid       <= valid_n;
            timeout     <= to_n;
        end
    end

    always_comb begin
        state_n = state;
        timer_n = timer;
        cm_n    = cm_cnt;
        sub_n   = sub_cnt;
        trig_n  = trigger;
        dist_n  = distance_cm;
        to_n    = timeout;
        valid_n = 1'b0;
        unique case (state)
            IDLE: begin
                if (cont || start) begin
                    state_n = TRIG;
                    trig_n  = 1'b1;
                    timer_n = '0;
                end
            end
            TRIG: begin
                if (timer == TRIG_LAST) begin
                    trig_n  = 1'b0;
                    timer_n = '0;
                    state_n = WAIT_RISE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            WAIT_RISE: begin
                // only a fresh low-to-high edge starts a measurement
                if (rise) begin
                    state_n = MEASURE;
                    cm_n    = '0;
                    sub_n   = '0;
                end else if (timer == WAIT_LAST) begin
                    state_n = DONE_TO;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            MEASURE: begin
                if (fall) begin
                    dist_n  = DIST_W'(cm_cnt);
                    to_n    = 1'b0;
                    valid_n = 1'b1;
                    timer_n = '0;
                    state_n = HOLDOFF;
                end else if (cm_cnt == CM_MAX) begin
                    state_n = DONE_TO;
                end else if (echo_s) begin
                    if (sub_cnt == SUB_LAST) begin
                        sub_n = '0;
                        cm_n  = cm_cnt + 1'b1;
                    end else begin
                        sub_n = sub_cnt + 1'b1;
                    end
                end
            end
            DONE_TO: begin
                dist_n  = DIST_W'(MAX_CM);
                to_n    = 1'b1;
                valid_n = 1'b1;
                timer_n = '0;
                state_n = HOLDOFF;
            end
            HOLDOFF: begin
                if (timer == HOLD_LAST) begin
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
